// File: rtl/mips_register_file_if.sv
// mips_register_file_if: read/write bus between the datapath and the register file.
interface mips_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              r_1_en;
    logic [ADDR_W-1:0] addr_r_1;
    logic [DATA_W-1:0] r_data_1;
    logic              r_2_en;
    logic [ADDR_W-1:0] addr_r_2;
    logic [DATA_W-1:0] r_data_2;
    logic              w_en;
    logic [ADDR_W-1:0] addr_w;
    logic [DATA_W-1:0] w_data;

    modport master (
        output r_1_en, addr_r_1, r_2_en, addr_r_2, w_en, addr_w, w_data,
        input  r_data_1, r_data_2
    );

    modport slave (
        input  r_1_en, addr_r_1, r_2_en, addr_r_2, w_en, addr_w, w_data,
        output r_data_1, r_data_2
    );
endinterface

// File: rtl/mips_register_file.sv
// mips_register_file: 32x32 GPR file, two registered read ports with write-through bypass, r0 reads zero.
module mips_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int N_REG  = 32
) (
    input logic clk,
    input logic rst_n,
    mips_register_file_if.slave bus
);
    localparam int IDX_W = $clog2(N_REG);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(N_REG);

    logic [DATA_W-1:0] regs [N_REG];
    logic [DATA_W-1:0] q_1, q_2, rd_1, rd_2;
    logic w_ok, ok_1, ok_2;

    // Index 0 and the out-of-range half of the address space are never stored or read.
    assign w_ok = bus.w_en && bus.addr_w < LIMIT && bus.addr_w != '0;
    assign ok_1 = bus.addr_r_1 < LIMIT && bus.addr_r_1 != '0;
    assign ok_2 = bus.addr_r_2 < LIMIT && bus.addr_r_2 != '0;

    always_comb begin
        rd_1 = !ok_1 ? '0 : (w_ok && bus.addr_r_1 == bus.addr_w) ? bus.w_data : regs[bus.addr_r_1[IDX_W-1:0]];
        rd_2 = !ok_2 ? '0 : (w_ok && bus.addr_r_2 == bus.addr_w) ? bus.w_data : regs[bus.addr_r_2[IDX_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REG; i++) regs[i] <= '0;
            q_1 <= '0;
            q_2 <= '0;
        end else begin
            if (w_ok) regs[bus.addr_w[IDX_W-1:0]] <= bus.w_data;
            if (bus.r_1_en) q_1 <= rd_1;
            if (bus.r_2_en) q_2 <= rd_2;
        end
    end

    assign bus.r_data_1 = q_1;
    assign bus.r_data_2 = q_2;
endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file: directed vectors with a cycle-tagged scoreboard checked by a separate monitor.
module tb_mips_register_file;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_register_file_if #(.DATA_W(32), .ADDR_W(6)) bus ();
    mips_register_file #(.DATA_W(32), .ADDR_W(6), .N_REG(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int          cyc;
        logic [31:0] e1;
        logic [31:0] e2;
        string       tag;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, want);
        end
    endtask

    // Monitor: outputs settle 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("%s/r1", e.tag), bus.r_data_1, e.e1);
            chk($sformatf("%s/r2", e.tag), bus.r_data_2, e.e2);
        end
    end

    task automatic drive(input logic we, input logic [5:0] aw, input logic [31:0] wd,
                         input logic r1, input logic [5:0] a1, input logic r2, input logic [5:0] a2,
                         input logic do_chk, input logic [31:0] e1, input logic [31:0] e2, input string tag);
        @(negedge clk);
        bus.w_en = we; bus.addr_w = aw; bus.w_data = wd;
        bus.r_1_en = r1; bus.addr_r_1 = a1; bus.r_2_en = r2; bus.addr_r_2 = a2;
        if (do_chk) q.push_back('{cyc + 1, e1, e2, tag});
    endtask

    function automatic logic [31:0] fillv(input int i);
        logic [31:0] v;
        v = 32'h01010101 * i;
        return v;
    endfunction

    initial begin
        bus.w_en = 0; bus.addr_w = 0; bus.w_data = 0;
        bus.r_1_en = 0; bus.addr_r_1 = 0; bus.r_2_en = 0; bus.addr_r_2 = 0;
        #2;
        chk("reset_r1", bus.r_data_1, 32'h0);
        chk("reset_r2", bus.r_data_2, 32'h0);
        // Enables during reset must be ignored.
        bus.w_en = 1; bus.addr_w = 6'd3; bus.w_data = 32'h77; bus.r_1_en = 1; bus.addr_r_1 = 6'd3;
        @(negedge clk);
        @(negedge clk);
        chk("reset_hold_r1", bus.r_data_1, 32'h0);
        rst_n = 1'b1;
        bus.w_en = 0; bus.r_1_en = 0;

        drive(1, 6'd10, 32'h0000AAAA, 0, 6'd0, 0, 6'd0, 1, 32'h0, 32'h0, "write10");
        drive(0, 6'd0, 32'h0, 1, 6'd10, 0, 6'd0, 1, 32'h0000AAAA, 32'h0, "read10_ch1");
        drive(0, 6'd0, 32'h0, 0, 6'd0, 1, 6'd10, 1, 32'h0000AAAA, 32'h0000AAAA, "read10_ch2");
        drive(0, 6'd0, 32'h0, 1, 6'd3, 0, 6'd0, 1, 32'h0, 32'h0000AAAA, "reg3_untouched");
        drive(1, 6'd0, 32'hFFFFFFFF, 0, 6'd0, 0, 6'd0, 1, 32'h0, 32'h0000AAAA, "write0_hold");
        drive(0, 6'd0, 32'h0, 1, 6'd0, 1, 6'd0, 1, 32'h0, 32'h0, "read0");
        drive(0, 6'd0, 32'h0, 1, 6'd10, 1, 6'd10, 1, 32'h0000AAAA, 32'h0000AAAA, "reread10");
        drive(1, 6'd40, 32'h1234, 0, 6'd0, 0, 6'd0, 1, 32'h0000AAAA, 32'h0000AAAA, "write40_hold");
        drive(0, 6'd0, 32'h0, 1, 6'd40, 1, 6'd40, 1, 32'h0, 32'h0, "read40");
        drive(0, 6'd0, 32'h0, 1, 6'd8, 1, 6'd40, 1, 32'h0, 32'h0, "alias8");
        drive(1, 6'd40, 32'h1234, 1, 6'd40, 1, 6'd8, 1, 32'h0, 32'h0, "write40_bypass");
        drive(1, 6'd5, 32'hDEADBEEF, 1, 6'd5, 1, 6'd5, 1, 32'hDEADBEEF, 32'hDEADBEEF, "bypass5");
        drive(1, 6'd0, 32'h5555, 1, 6'd0, 1, 6'd5, 1, 32'h0, 32'hDEADBEEF, "bypass0");

        for (int i = 1; i < 32; i++)
            drive(1, 6'(i), fillv(i), 0, 6'd0, 0, 6'd0, 0, 32'h0, 32'h0, "fill");
        for (int i = 0; i < 32; i++)
            drive(0, 6'd0, 32'h0, 1, 6'(i), 1, 6'(31 - i), 1, fillv(i), fillv(31 - i),
                  $sformatf("pair%0d", i));
        drive(0, 6'd0, 32'h0, 1, 6'd63, 1, 6'd33, 1, 32'h0, 32'h0, "read_hi");

        drive(1, 6'd10, 32'h0000AAAA, 1, 6'd10, 0, 6'd0, 1, 32'h0000AAAA, 32'h0, "setup_reset");
        drive(0, 6'd0, 32'h0, 0, 6'd0, 1, 6'd7, 1, 32'h0000AAAA, fillv(7), "pre_reset");
        @(negedge clk);
        bus.r_1_en = 0; bus.r_2_en = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_r1", bus.r_data_1, 32'h0);
        chk("async_reset_r2", bus.r_data_2, 32'h0);
        #1 rst_n = 1'b1;
        drive(0, 6'd0, 32'h0, 1, 6'd10, 1, 6'd7, 1, 32'h0, 32'h0, "post_reset");

        drive(0, 6'd0, 32'h0, 0, 6'd0, 0, 6'd0, 0, 32'h0, 32'h0, "idle");
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
